// File: rtl/tick_sched_pkg.sv
// Shared types and elaboration helpers for the tick scheduler.
package tick_sched_pkg;

  typedef enum logic {
    IDLE,
    APPLY
  } cfg_state_t;

  function automatic int unsigned pre_div(input int unsigned clk_hz,
                                          input int unsigned base_hz);
    return clk_hz / base_hz;
  endfunction

  // Channel index carries one spare bit so out-of-range requests are visible.
  function automatic int unsigned ch_width(input int unsigned nch);
    return $clog2(nch) + 1;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One scheduler channel: period register, base-tick counter, pulse and square-wave outputs.
module tick_channel #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             base_tick,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_period,
  output logic             tick_out,
  output logic             sq_out
);

  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;

  // A config write takes priority over a coincident base tick.
  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    sq_d     = sq_q;
    if (wr_en) begin
      period_d = wr_period;
      cnt_d    = '0;
    end else if (base_tick && (period_q != '0)) begin
      if (cnt_q == period_q - 1'b1) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        sq_d   = ~sq_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      period_q <= '0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      sq_q     <= 1'b0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      sq_q     <= sq_d;
    end
  end

  assign tick_out = tick_q;
  assign sq_out   = sq_q;

endmodule

// File: rtl/tick_scheduler.sv
// Shared timebase: prescaler to a base tick, config FSM, and NCH programmable divider channels.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned BASE_HZ = 1_000,
  parameter int unsigned NCH     = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [$clog2(NCH):0] cfg_ch,
  input  logic [CNT_W-1:0]     cfg_period,
  output logic                 cfg_err,
  output logic                 base_tick,
  output logic [NCH-1:0]       tick_out,
  output logic [NCH-1:0]       sq_out
);

  localparam int unsigned       PRE_DIV  = pre_div(CLK_HZ, BASE_HZ);
  localparam int unsigned       PRE_W    = $clog2(PRE_DIV);
  localparam int unsigned       CH_W     = ch_width(NCH);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRE_DIV - 1);
  localparam logic [CH_W-1:0]   NCH_IDX  = CH_W'(NCH);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             base_tick_q, base_tick_d;
  cfg_state_t       state_q, state_d;
  logic [CH_W-1:0]  cfg_ch_q, cfg_ch_d;
  logic [CNT_W-1:0] cfg_period_q, cfg_period_d;
  logic             cfg_err_q, cfg_err_d;
  logic             accept;
  logic             apply;
  logic             chan_base;
  logic [NCH-1:0]   wr_en;

  always_comb begin
    pre_d       = '0;
    base_tick_d = 1'b0;
    if (run) begin
      pre_d       = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
      base_tick_d = (pre_q == PRE_LAST);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = rst_n && (state_q == IDLE);
    apply     = (state_q == APPLY);
  end

  assign accept = cfg_valid && cfg_ready;

  // Error flag is registered at accept so its pulse lines up with the APPLY cycle.
  always_comb begin
    cfg_ch_d     = cfg_ch_q;
    cfg_period_d = cfg_period_q;
    cfg_err_d    = 1'b0;
    if (accept) begin
      cfg_ch_d     = cfg_ch;
      cfg_period_d = cfg_period;
      cfg_err_d    = run && (cfg_ch >= NCH_IDX);
    end
  end

  always_comb begin
    wr_en = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      wr_en[k] = apply && (cfg_ch_q == CH_W'(k));
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      pre_q        <= '0;
      base_tick_q  <= 1'b0;
      cfg_ch_q     <= '0;
      cfg_period_q <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      base_tick_q  <= base_tick_d;
      cfg_ch_q     <= cfg_ch_d;
      cfg_period_q <= cfg_period_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign chan_base = base_tick_q && run;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    tick_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .base_tick(chan_base),
      .wr_en    (wr_en[k]),
      .wr_period(cfg_period_q),
      .tick_out (tick_out[k]),
      .sq_out   (sq_out[k])
    );
  end

  assign base_tick = base_tick_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with PRE_DIV=10, NCH=4, hand-computed event cycles.
module tb_tick_scheduler;

  localparam int unsigned NCH   = 4;
  localparam int unsigned CNT_W = 16;

  logic                 clk_in = 1'b0;
  logic                 rst_n;
  logic                 run;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [$clog2(NCH):0] cfg_ch;
  logic [CNT_W-1:0]     cfg_period;
  logic                 cfg_err;
  logic                 base_tick;
  logic [NCH-1:0]       tick_out;
  logic [NCH-1:0]       sq_out;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int          cyc   = 0;

  logic [3:0] exp_tick [int];
  logic       exp_base [int];

  tick_scheduler #(
    .CLK_HZ (1000),
    .BASE_HZ(100),
    .NCH    (NCH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .run       (run),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_period(cfg_period),
    .cfg_err   (cfg_err),
    .base_tick (base_tick),
    .tick_out  (tick_out),
    .sq_out    (sq_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit track);
    logic [3:0] et;
    logic       eb;
    @(posedge clk_in);
    #1;
    cyc++;
    if (track) begin
      et = exp_tick.exists(cyc) ? exp_tick[cyc] : 4'b0000;
      eb = exp_base.exists(cyc) ? exp_base[cyc] : 1'b0;
      check_eq("tick_out", 32'(tick_out), 32'(et));
      check_eq("base_tick", 32'(base_tick), 32'(eb));
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step(1'b1);
  endtask

  task automatic drive_cfg(input logic v, input int ch, input int p);
    cfg_valid  = v;
    cfg_ch     = 3'(ch);
    cfg_period = 16'(p);
  endtask

  initial begin
    rst_n = 1'b0;
    run   = 1'b1;
    drive_cfg(1'b0, 0, 0);

    for (int c = 10; c <= 140; c += 10) exp_base[c] = 1'b1;
    exp_base[180] = 1'b1;
    exp_base[190] = 1'b1;
    exp_base[200] = 1'b1;

    exp_tick[51]  = 4'b0001;
    exp_tick[61]  = 4'b0010;
    exp_tick[71]  = 4'b0010;
    exp_tick[81]  = 4'b0011;
    exp_tick[91]  = 4'b0010;
    exp_tick[101] = 4'b0110;
    exp_tick[111] = 4'b0010;
    exp_tick[121] = 4'b0010;
    exp_tick[131] = 4'b0010;
    exp_tick[141] = 4'b0011;
    exp_tick[181] = 4'b0010;
    exp_tick[191] = 4'b0010;
    exp_tick[201] = 4'b0011;

    repeat (3) @(posedge clk_in);
    #1;
    check_eq("rst_ready", 32'(cfg_ready), 32'(0));
    check_eq("rst_base", 32'(base_tick), 32'(0));
    check_eq("rst_tick", 32'(tick_out), 32'(0));
    check_eq("rst_sq", 32'(sq_out), 32'(0));
    check_eq("rst_err", 32'(cfg_err), 32'(0));

    rst_n = 1'b1;
    cyc   = 0;
    step(1'b1);
    check_eq("ready_after_rst", 32'(cfg_ready), 32'(1));
    run_to(20);
    check_eq("sq_idle", 32'(sq_out), 32'(0));

    drive_cfg(1'b1, 0, 3);
    step(1'b1);
    check_eq("ready_apply_ch0", 32'(cfg_ready), 32'(0));
    drive_cfg(1'b0, 0, 0);
    step(1'b1);
    check_eq("ready_back_ch0", 32'(cfg_ready), 32'(1));

    run_to(51);
    check_eq("sq_51", 32'(sq_out), 32'(4'b0001));
    run_to(52);

    drive_cfg(1'b1, 1, 1);
    step(1'b1);
    check_eq("ready_53", 32'(cfg_ready), 32'(0));
    drive_cfg(1'b1, 2, 5);
    step(1'b1);
    check_eq("ready_54", 32'(cfg_ready), 32'(1));
    step(1'b1);
    check_eq("ready_55", 32'(cfg_ready), 32'(0));
    drive_cfg(1'b0, 0, 0);
    step(1'b1);
    check_eq("ready_56", 32'(cfg_ready), 32'(1));

    run_to(61);
    check_eq("sq_61", 32'(sq_out), 32'(4'b0011));
    run_to(81);
    check_eq("sq_81", 32'(sq_out), 32'(4'b0010));
    run_to(101);
    check_eq("sq_101", 32'(sq_out), 32'(4'b0110));

    run_to(109);
    drive_cfg(1'b1, 0, 3);
    step(1'b1);
    check_eq("ready_110", 32'(cfg_ready), 32'(0));
    drive_cfg(1'b0, 0, 0);
    step(1'b1);
    check_eq("ready_111", 32'(cfg_ready), 32'(1));

    run_to(112);
    check_eq("err_idle", 32'(cfg_err), 32'(0));
    drive_cfg(1'b1, 7, 9);
    step(1'b1);
    check_eq("err_pulse", 32'(cfg_err), 32'(1));
    check_eq("ready_err", 32'(cfg_ready), 32'(0));
    drive_cfg(1'b0, 0, 0);
    step(1'b1);
    check_eq("err_clear", 32'(cfg_err), 32'(0));

    drive_cfg(1'b1, 2, 0);
    step(1'b1);
    drive_cfg(1'b0, 0, 0);
    step(1'b1);
    check_eq("sq_116", 32'(sq_out), 32'(4'b0100));

    run_to(141);
    check_eq("sq_141", 32'(sq_out), 32'(4'b0111));
    run_to(145);
    run = 1'b0;
    run_to(160);
    check_eq("sq_frozen", 32'(sq_out), 32'(4'b0111));
    run_to(170);
    run = 1'b1;
    run_to(181);
    check_eq("sq_181", 32'(sq_out), 32'(4'b0101));
    run_to(201);
    check_eq("sq_201", 32'(sq_out), 32'(4'b0100));

    run_to(203);
    drive_cfg(1'b1, 1, 4);
    step(1'b1);
    drive_cfg(1'b0, 0, 0);
    rst_n = 1'b0;
    step(1'b1);
    check_eq("mid_rst_sq", 32'(sq_out), 32'(0));
    check_eq("mid_rst_err", 32'(cfg_err), 32'(0));
    check_eq("mid_rst_ready", 32'(cfg_ready), 32'(0));

    rst_n = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      step(1'b0);
      if (i == 1) check_eq("post_rst_ready", 32'(cfg_ready), 32'(1));
      check_eq("post_rst_tick", 32'(tick_out), 32'(0));
      check_eq("post_rst_base", 32'(base_tick), 32'((i % 10) == 0));
    end
    check_eq("post_rst_sq", 32'(sq_out), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
